// File: rtl/sgb_packet_rx_if.sv
// Joypad-write and buffer-read bundle between the GB core / SGB mapper and
// the SGB packet receiver.
interface sgb_packet_rx_if;
  logic       joy_wr;
  logic       p14;
  logic       p15;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       ack;
  logic       pkt_avail;
  logic       pkt_done;
  logic       pkt_ovr;
  logic       pkt_err;
  logic       busy;

  modport master (
    output joy_wr, p14, p15, rd_addr, ack,
    input  rd_data, pkt_avail, pkt_done, pkt_ovr, pkt_err, busy
  );

  modport slave (
    input  joy_wr, p14, p15, rd_addr, ack,
    output rd_data, pkt_avail, pkt_done, pkt_ovr, pkt_err, busy
  );
endinterface

// File: rtl/sgb_packet_rx.sv
// Super Game Boy command-packet receiver: decodes P14/P15 writes into a
// 16-byte LSB-first frame and holds the last committed packet for the mapper.
// Optional stop-bit checking is enabled by defining SGB_PKT_STOPCHK_EN.
module sgb_packet_rx #(
  parameter int PKT_BYTES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sgb_packet_rx_if.slave bus_if
);

  localparam int         PKT_BITS = PKT_BYTES * 8;
  localparam int         IDX_W    = $clog2(PKT_BITS);
  localparam logic [7:0] CNT_FULL = 8'(PKT_BITS);

  localparam logic [1:0] CODE_RST  = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_ZERO = 2'b10;
  localparam logic [1:0] CODE_IDLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RECV  = 3'd2,
    GAP   = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [PKT_BITS-1:0]   shift_q;
  logic [7:0]            buf_q [PKT_BYTES];
  logic [7:0]            rd_data_q;
  logic                  pkt_avail_q, pkt_avail_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  pkt_ovr_q, pkt_ovr_d;
  logic                  busy_q;
  logic [1:0]            code_s;
  logic                  shift_wr_s;
  logic                  commit_s;
  logic                  load_s;
`ifdef SGB_PKT_STOPCHK_EN
  logic                  err_s;
  logic                  pkt_err_q;
`endif

  assign code_s = {bus_if.p15, bus_if.p14};

  // Next-state decode of the joypad write protocol
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_wr_s = 1'b0;
    commit_s   = 1'b0;
`ifdef SGB_PKT_STOPCHK_EN
    err_s      = 1'b0;
`endif
    if (bus_if.joy_wr) begin
      case (state_q)
        IDLE: begin
          if (code_s == CODE_RST) begin
            state_d = ARMED;
            cnt_d   = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          case (code_s)
            CODE_IDLE: state_d = RECV;
            CODE_RST:  state_d = ARMED;
            default:   state_d = IDLE;
          endcase
        end
        RECV: begin
          case (code_s)
            CODE_ONE, CODE_ZERO: begin
              shift_wr_s = 1'b1;
              cnt_d      = cnt_q + 8'd1;
              state_d    = GAP;
            end
            CODE_RST: begin
              state_d = ARMED;
              cnt_d   = 8'd0;
            end
            default: state_d = RECV;
          endcase
        end
        GAP: begin
          // A repeated bit code between bits is the same bit rewritten; only 11 advances
          case (code_s)
            CODE_IDLE: state_d = (cnt_q == CNT_FULL) ? STOP : RECV;
            CODE_RST: begin
              state_d = ARMED;
              cnt_d   = 8'd0;
            end
            default: state_d = GAP;
          endcase
        end
        STOP: begin
          case (code_s)
            CODE_ZERO: begin
              commit_s = 1'b1;
              state_d  = IDLE;
            end
            CODE_ONE: begin
`ifdef SGB_PKT_STOPCHK_EN
              err_s    = 1'b1;
`else
              commit_s = 1'b1;
`endif
              state_d  = IDLE;
            end
            CODE_RST: begin
              state_d = ARMED;
              cnt_d   = 8'd0;
            end
            default: state_d = STOP;
          endcase
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Commit arbitration: an ack in the commit cycle frees the buffer for the new packet
  always_comb begin
    pkt_avail_d = pkt_avail_q;
    pkt_done_d  = 1'b0;
    pkt_ovr_d   = 1'b0;
    load_s      = 1'b0;
    if (commit_s) begin
      if (!pkt_avail_q || bus_if.ack) begin
        load_s      = 1'b1;
        pkt_done_d  = 1'b1;
        pkt_avail_d = 1'b1;
      end else begin
        pkt_ovr_d   = 1'b1;
      end
    end else if (bus_if.ack) begin
      pkt_avail_d = 1'b0;
    end else begin
      pkt_avail_d = pkt_avail_q;
    end
  end

  // Receiver state, shift store, committed buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      shift_q     <= '0;
      for (int i = 0; i < PKT_BYTES; i++) begin
        buf_q[i] <= 8'h00;
      end
      rd_data_q   <= 8'h00;
      pkt_avail_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ovr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (shift_wr_s) begin
        shift_q[cnt_q[IDX_W-1:0]] <= bus_if.p14;
      end
      if (load_s) begin
        for (int i = 0; i < PKT_BYTES; i++) begin
          buf_q[i] <= shift_q[i*8 +: 8];
        end
      end
      // Reads sample the pre-commit buffer, so a same-cycle read returns the old byte
      rd_data_q   <= buf_q[bus_if.rd_addr];
      pkt_avail_q <= pkt_avail_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ovr_q   <= pkt_ovr_d;
      busy_q      <= (state_d != IDLE);
    end
  end

`ifdef SGB_PKT_STOPCHK_EN
  // Stop-bit error pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_err_q <= 1'b0;
    end else begin
      pkt_err_q <= err_s;
    end
  end

  assign bus_if.pkt_err = pkt_err_q;
`else
  assign bus_if.pkt_err = 1'b0;
`endif

  assign bus_if.rd_data   = rd_data_q;
  assign bus_if.pkt_avail = pkt_avail_q;
  assign bus_if.pkt_done  = pkt_done_q;
  assign bus_if.pkt_ovr   = pkt_ovr_q;
  assign bus_if.busy      = busy_q;

endmodule

// File: tb/tb_sgb_packet_rx.sv
// Scoreboard bench for sgb_packet_rx: stimulus queues expected packet events
// and read bytes; independent monitors pop and compare when the DUT responds.
module tb_sgb_packet_rx;

  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_OVR  = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0] ev;
    logic       avail;
  } exp_ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sgb_packet_rx_if bus();

  sgb_packet_rx #(.PKT_BYTES(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_ev_t    ev_q[$];
  logic [7:0] rd_exp_q[$];
  logic [3:0] rd_adr_q[$];
  logic       rd_req  = 1'b0;
  logic       rd_pend = 1'b0;
  logic [1:0] mon_ev;
  exp_ev_t    mon_e;
  logic [7:0] mon_rd;
  logic [3:0] mon_ad;

  logic [127:0] pkt_clean, pkt_ff, pkt_55;

  always @(posedge clk) rd_pend <= rd_req;

  // Event and read monitor
  always @(negedge clk) begin
    if (rst_n && (bus.pkt_done || bus.pkt_ovr || bus.pkt_err)) begin
      mon_ev = bus.pkt_done ? EV_DONE : (bus.pkt_ovr ? EV_OVR : EV_ERR);
      n_checks++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_event: got event %0d (avail %0b) at %0t, expected no event",
                 mon_ev, bus.pkt_avail, $time);
      end else begin
        mon_e = ev_q.pop_front();
        if (mon_e.ev !== mon_ev || mon_e.avail !== bus.pkt_avail) begin
          n_fail++;
          $display("FAIL pkt_event: got event %0d avail %0b, expected event %0d avail %0b at %0t",
                   mon_ev, bus.pkt_avail, mon_e.ev, mon_e.avail, $time);
        end
      end
    end
    if (rd_pend) begin
      mon_rd = rd_exp_q.pop_front();
      mon_ad = rd_adr_q.pop_front();
      n_checks++;
      if (bus.rd_data !== mon_rd) begin
        n_fail++;
        $display("FAIL rd_data[%0d]: got 0x%02h, expected 0x%02h at %0t",
                 mon_ad, bus.rd_data, mon_rd, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [1:0] ev, input logic av);
    exp_ev_t e;
    e.ev    = ev;
    e.avail = av;
    ev_q.push_back(e);
  endtask

  task automatic jw(input logic [1:0] c);
    @(negedge clk);
    bus.joy_wr = 1'b1;
    bus.p15    = c[1];
    bus.p14    = c[0];
  endtask

  task automatic jw_end();
    @(negedge clk);
    bus.joy_wr = 1'b0;
    bus.ack    = 1'b0;
    bus.p15    = 1'b1;
    bus.p14    = 1'b1;
  endtask

  task automatic send_bits(input logic [127:0] pkt, input int nbits, input bit dup);
    logic [1:0] c;
    for (int i = 0; i < nbits; i++) begin
      c = pkt[i] ? 2'b01 : 2'b10;
      jw(c);
      if (dup) jw(c);
      jw(2'b11);
    end
  endtask

  task automatic send(input logic [127:0] pkt, input logic [1:0] stop,
                      input bit dup, input bit ack_stop);
    jw(2'b00);
    jw(2'b11);
    send_bits(pkt, 128, dup);
    jw(stop);
    bus.ack = ack_stop;
    jw_end();
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    bus.rd_addr = a;
    rd_req      = 1'b1;
    rd_exp_q.push_back(exp);
    rd_adr_q.push_back(a);
    @(negedge clk);
    rd_req      = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"},   32'(bus.rd_data),   32'h0);
    chk({tag, "_pkt_avail"}, 32'(bus.pkt_avail), 32'h0);
    chk({tag, "_pkt_done"},  32'(bus.pkt_done),  32'h0);
    chk({tag, "_pkt_ovr"},   32'(bus.pkt_ovr),   32'h0);
    chk({tag, "_pkt_err"},   32'(bus.pkt_err),   32'h0);
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
  endtask

  initial begin
    bus.joy_wr  = 1'b0;
    bus.p14     = 1'b1;
    bus.p15     = 1'b1;
    bus.rd_addr = 4'd0;
    bus.ack     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pkt_clean[i*8 +: 8] = (i == 0) ? 8'h89 : 8'(i);
    end
    pkt_ff = {128{1'b1}};
    pkt_55 = {16{8'h55}};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ARMED aborts back to IDLE on a bit code
    jw(2'b00);
    jw_end();
    chk("armed_busy", 32'(bus.busy), 32'h1);
    jw(2'b01);
    jw_end();
    chk("abort_busy", 32'(bus.busy), 32'h0);

    // Clean packet
    expect_ev(EV_DONE, 1'b1);
    send(pkt_clean, 2'b10, 1'b0, 1'b0);
    chk("clean_avail", 32'(bus.pkt_avail), 32'h1);
    chk("clean_busy",  32'(bus.busy),      32'h0);
    rd(4'd0,  8'h89);
    rd(4'd15, 8'h0F);
    rd(4'd7,  8'h07);

    // ack clears avail, buffer retained
    ack_pulse();
    chk("ack_avail", 32'(bus.pkt_avail), 32'h0);
    rd(4'd0, 8'h89);

    // Restart after 40 bits
    jw(2'b00);
    jw(2'b11);
    send_bits(pkt_clean, 40, 1'b0);
    jw_end();
    chk("partial_busy", 32'(bus.busy), 32'h1);
    expect_ev(EV_DONE, 1'b1);
    send(pkt_ff, 2'b10, 1'b0, 1'b0);
    rd(4'd0,  8'hFF);
    rd(4'd15, 8'hFF);
    ack_pulse();

    // Overrun, then commit with ack in the commit cycle
    expect_ev(EV_DONE, 1'b1);
    send(pkt_clean, 2'b10, 1'b0, 1'b0);
    expect_ev(EV_OVR, 1'b1);
    send(pkt_55, 2'b10, 1'b0, 1'b0);
    rd(4'd0, 8'h89);
    expect_ev(EV_DONE, 1'b1);
    send(pkt_55, 2'b10, 1'b0, 1'b1);
    chk("ovr_ack_avail", 32'(bus.pkt_avail), 32'h1);
    rd(4'd0, 8'h55);
    rd(4'd9, 8'h55);
    ack_pulse();

    // Duplicate bit writes
    expect_ev(EV_DONE, 1'b1);
    send(pkt_clean, 2'b10, 1'b1, 1'b0);
    rd(4'd0,  8'h89);
    rd(4'd15, 8'h0F);
    ack_pulse();

    // Stop bit 01
`ifdef SGB_PKT_STOPCHK_EN
    expect_ev(EV_ERR, 1'b0);
    send(pkt_ff, 2'b01, 1'b0, 1'b0);
    chk("badstop_avail", 32'(bus.pkt_avail), 32'h0);
    rd(4'd0, 8'h89);
`else
    expect_ev(EV_DONE, 1'b1);
    send(pkt_ff, 2'b01, 1'b0, 1'b0);
    chk("badstop_avail", 32'(bus.pkt_avail), 32'h1);
    rd(4'd0, 8'hFF);
`endif
    ack_pulse();

    // Async reset at bit 70 with a packet pending
    expect_ev(EV_DONE, 1'b1);
    send(pkt_clean, 2'b10, 1'b0, 1'b0);
    rd(4'd0, 8'h89);
    jw(2'b00);
    jw(2'b11);
    send_bits(pkt_55, 70, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    bus.joy_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'd0, 8'h00);
    expect_ev(EV_DONE, 1'b1);
    send(pkt_clean, 2'b10, 1'b0, 1'b0);
    rd(4'd0,  8'h89);
    rd(4'd15, 8'h0F);

    repeat (3) @(negedge clk);
    chk("events_outstanding", 32'(ev_q.size()),     32'h0);
    chk("reads_outstanding",  32'(rd_exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
